// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, config_reg field positions,
// receiver FSM state encoding and the default oversampling ratio.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int CFG_STOP = 2;
  localparam int CFG_BITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/receiver_fsm.sv
// UART receive deframer: rx synchronizer, tick/bit counters, shift register, parity/stop checks.
// Optional RX_MAJORITY_EN: 2-of-3 vote over samples at counts 6, 7, 8 instead of one sample at 7.
module receiver_fsm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  input  logic [3:0] config_reg,
  output logic       frame_done_o,
  output logic [7:0] data_o,
  output logic       perr_o,
  output logic       ferr_o
);

  localparam int CW   = $clog2(OVERSAMPLE);
  localparam int SAMP = OVERSAMPLE / 2 - 1;
`ifdef RX_MAJORITY_EN
  localparam int DEC  = SAMP + 1;
`else
  localparam int DEC  = SAMP;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [3:0]             cfg_q, cfg_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   armed_q, armed_d;
  logic                   bit_val, mid, last_tick, has_par;
  logic [2:0]             nbits_m1, stop_last;
  logic [7:0]             data_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_EN
  logic [1:0] samp_q;
  // Collects the count-6 and count-7 samples; the count-8 sample is the live rx_s.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) samp_q <= 2'b11;
    else if (tick && (cnt_q == CW'(SAMP - 1) || cnt_q == CW'(SAMP)))
      samp_q <= {samp_q[0], rx_s};
  end
  assign bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign mid       = (cnt_q == CW'(DEC));
  assign last_tick = (cnt_q == CW'(OVERSAMPLE - 1));
  assign has_par   = (cfg_q[1:0] == PAR_ODD) || (cfg_q[1:0] == PAR_EVEN);
  assign nbits_m1  = cfg_q[CFG_BITS] ? 3'd7 : 3'd6;
  assign stop_last = cfg_q[CFG_STOP] ? 3'd1 : 3'd0;
  // 7-bit frames end up in shift_q[7:1] because bits enter at the MSB.
  assign data_w    = cfg_q[CFG_BITS] ? shift_q : {1'b0, shift_q[7:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cfg_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cfg_q   <= cfg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    cfg_d        = cfg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    armed_d      = armed_q;
    frame_done_o = 1'b0;
    if (tick) begin
      cnt_d = last_tick ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          // A start edge only counts once the line has been seen high after the last frame.
          if (rx_s) armed_d = 1'b1;
          else if (armed_q) state_d = ST_START;
        end
        ST_START: begin
          if (mid && bit_val) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (last_tick) begin
            state_d = ST_DATA;
            bit_d   = '0;
            shift_d = '0;
            cfg_d   = config_reg;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        ST_DATA: begin
          if (mid) shift_d = {bit_val, shift_q[7:1]};
          if (last_tick) begin
            if (bit_q == nbits_m1) begin
              bit_d   = '0;
              state_d = has_par ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (mid) perr_d = (cfg_q[1:0] == PAR_ODD) ? ~(^data_w ^ bit_val) : (^data_w ^ bit_val);
          if (last_tick) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end
        end
        ST_STOP: begin
          if (mid) begin
            ferr_d = ferr_q | ~bit_val;
            if (bit_q == stop_last) begin
              frame_done_o = 1'b1;
              state_d      = ST_IDLE;
              cnt_d        = '0;
              armed_d      = 1'b0;
            end
          end else if (last_tick) begin
            bit_d = bit_q + 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign data_o = data_w;
  assign perr_o = perr_q;
  assign ferr_o = ferr_d;

endmodule

// File: rtl/receiver_top.sv
// UART receiver top: deframer plus host-side data_out register and flag/overrun handshake.
// Build option RX_MAJORITY_EN (in receiver_fsm) selects 3-sample majority voting.
module receiver_top
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  input  logic [3:0] config_reg,
  input  logic       read_en,
  output logic [7:0] data_out,
  output logic       rx_flag,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  logic       done;
  logic [7:0] fsm_data;
  logic       fsm_perr, fsm_ferr;
  logic [7:0] data_q, data_d;
  logic       flag_q, flag_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;

  receiver_fsm #(
    .OVERSAMPLE (OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .rx          (rx),
    .config_reg  (config_reg),
    .frame_done_o(done),
    .data_o      (fsm_data),
    .perr_o      (fsm_perr),
    .ferr_o      (fsm_ferr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      flag_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      flag_q <= flag_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    data_d = data_q;
    flag_d = flag_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (done) begin
      // A read in the completion cycle frees the buffer for the new frame.
      if (!flag_q || read_en) begin
        data_d = fsm_data;
        perr_d = fsm_perr;
        ferr_d = fsm_ferr;
        flag_d = 1'b1;
        if (read_en) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (read_en && flag_q) begin
      flag_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  assign data_out    = data_q;
  assign rx_flag     = flag_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_receiver_top.sv
// Scoreboard bench for receiver_top: frames are queued as driven and compared on each rx_flag rise.
module tb_receiver_top;

  localparam int TPER = 4;
  localparam int OS   = 16;
  localparam int BITCLK = OS * TPER;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick;
  logic       rx = 1'b1;
  logic [3:0] config_reg = 4'b0000;
  logic       read_en = 1'b0;
  logic [7:0] data_out;
  logic       rx_flag, parity_err, frame_err, overrun_err;

  int checks = 0;
  int errors = 0;
  int tdiv = 0;
  logic flag_prev = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t sb[$];

  receiver_top #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .rx         (rx),
    .config_reg (config_reg),
    .read_en    (read_en),
    .data_out   (data_out),
    .rx_flag    (rx_flag),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tdiv <= (tdiv == TPER - 1) ? 0 : tdiv + 1;
  assign tick = (tdiv == 0);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every rising rx_flag must match the oldest queued frame.
  always @(negedge clk) begin
    if (reset && rx_flag && !flag_prev) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_frame", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", data_out, e.d);
        check("sb_parity_err", parity_err, e.pe);
        check("sb_frame_err", frame_err, e.fe);
      end
    end
    flag_prev = rx_flag;
  end

  function automatic logic [7:0] mask_data(input logic [7:0] d, input int nb);
    return (nb == 8) ? d : (d & 8'h7F);
  endfunction

  // Parity bit that makes the frame correct for the given mode.
  function automatic logic good_par(input logic [7:0] d, input int nb, input logic [1:0] pm);
    int ones;
    ones = $countones(mask_data(d, nb));
    return (pm == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic bit_time(input logic v);
    rx = v;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                            input logic pb, input logic two_stop, input logic s2);
    bit_time(1'b0);
    for (int i = 0; i < nb; i++) bit_time(d[i]);
    if (has_par) bit_time(pb);
    bit_time(1'b1);
    if (two_stop) bit_time(s2);
    bit_time(1'b1);
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic wait_flag();
    int n;
    n = 0;
    while (!rx_flag && n < 4 * BITCLK) begin
      @(negedge clk);
      n++;
    end
    check("flag_timeout", rx_flag, 1);
  endtask

  task automatic do_read();
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    check("read_clears_flag", rx_flag, 0);
  endtask

  initial begin
    logic pb;
    repeat (5) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_flag", rx_flag, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun_err, 0);
    reset = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);

    // 8-bit, even parity, one stop
    config_reg = 4'b1010;
    pb = good_par(8'h5A, 8, 2'b10);
    check("even_par_bit_0x5A", pb, 0);
    push(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 8, 1'b1, pb, 1'b0, 1'b1);
    wait_flag();
    do_read();

    // 7-bit, odd parity, wrong parity bit
    config_reg = 4'b0001;
    pb = ~good_par(8'h55, 7, 2'b01);
    push(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 7, 1'b1, pb, 1'b0, 1'b1);
    wait_flag();
    do_read();

    // 8-bit, no parity, two stops with second stop low
    config_reg = 4'b1100;
    push(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_flag();
    do_read();

    // Overrun: second frame arrives while the first is unread
    config_reg = 4'b1000;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_data_held", data_out, 8'h11);
    check("ovr_set", overrun_err, 1);
    do_read();
    check("ovr_cleared_by_read", overrun_err, 0);
    push(8'h33, 1'b0, 1'b0);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_flag();
    check("after_ovr_data", data_out, 8'h33);
    check("after_ovr_flag", overrun_err, 0);
    do_read();

    // False start: 4-tick low pulse
    rx = 1'b0;
    repeat (4 * TPER) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    check("glitch_no_flag", rx_flag, 0);
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_flag();
    do_read();

    // Reset in the middle of DATA
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b1);
    #2 reset = 1'b0;
    #1;
    check("midrst_data", data_out, 0);
    check("midrst_flag", rx_flag, 0);
    check("midrst_ovr", overrun_err, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_flag();
    do_read();

    repeat (BITCLK) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
